// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed big-endian byte stream into instruction memory, holding the core in reset until complete.
// One write cycle per word (4 bytes in 5 cycles at best); rx_ready drops during WRITE/IDLE/DONE/ERR and the source must hold its byte.
module imem_boot_loader #(
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned DEPTH = 32'd1 << ADDR_WIDTH;
  localparam int          TW    = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t        state;
  state_t        stateNext;
  logic [15:0]   wordCount;
  logic [31:0]   wordIdx;
  logic [1:0]    byteIdx;
  logic [TW-1:0] tmoCnt;
  logic          xfer;
  logic          tmoHit;
  logic [15:0]   lenFull;
  logic          lastWord;

  assign rx_ready = (state == S_LEN_HI) || (state == S_LEN_LO) || (state == S_DATA);
  assign xfer     = rx_valid & rx_ready;
  assign imem_we  = (state == S_WRITE);
  assign busy     = rx_ready || (state == S_WRITE);
  assign done     = (state == S_DONE);
  assign error    = (state == S_ERR);
  assign lenFull  = {wordCount[15:8], rx_data};
  // The idle cycle that would bring the counter to TIMEOUT_CYCLES is the one that errors out.
  assign tmoHit   = (tmoCnt == TW'(TIMEOUT_CYCLES - 1));
  assign lastWord = (wordIdx == ({16'd0, wordCount} - 32'd1));

  always_comb begin
    stateNext = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) stateNext = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (xfer)        stateNext = S_LEN_LO;
        else if (tmoHit) stateNext = S_ERR;
      end
      S_LEN_LO: begin
        if (xfer) begin
          if (lenFull == 16'd0)                stateNext = S_DONE;
          else if ({16'd0, lenFull} > DEPTH)   stateNext = S_ERR;
          else                                 stateNext = S_DATA;
        end else if (tmoHit) begin
          stateNext = S_ERR;
        end
      end
      S_DATA: begin
        if (xfer) begin
          if (byteIdx == 2'd3) stateNext = S_WRITE;
        end else if (tmoHit) begin
          stateNext = S_ERR;
        end
      end
      S_WRITE: begin
        stateNext = lastWord ? S_DONE : S_DATA;
      end
      default: stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      core_reset <= 1'b1;
      imem_addr  <= '0;
      imem_wdata <= '0;
      wordCount  <= '0;
      wordIdx    <= '0;
      byteIdx    <= '0;
      tmoCnt     <= '0;
    end else begin
      state      <= stateNext;
      core_reset <= (stateNext != S_DONE);
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            wordIdx <= '0;
            byteIdx <= '0;
            tmoCnt  <= '0;
          end
        end
        S_LEN_HI: begin
          if (xfer) begin
            wordCount[15:8] <= rx_data;
            tmoCnt          <= '0;
          end else begin
            tmoCnt <= tmoCnt + 1'b1;
          end
        end
        S_LEN_LO: begin
          if (xfer) begin
            wordCount[7:0] <= rx_data;
            byteIdx        <= '0;
            tmoCnt         <= '0;
          end else begin
            tmoCnt <= tmoCnt + 1'b1;
          end
        end
        S_DATA: begin
          if (xfer) begin
            imem_wdata <= {imem_wdata[23:0], rx_data};
            byteIdx    <= byteIdx + 2'd1;
            tmoCnt     <= '0;
            // Latch the address now so it stays stable after wordIdx advances.
            if (byteIdx == 2'd3) imem_addr <= wordIdx[ADDR_WIDTH-1:0];
          end else begin
            tmoCnt <= tmoCnt + 1'b1;
          end
        end
        S_WRITE: begin
          tmoCnt  <= '0;
          byteIdx <= '0;
          if (!lastWord) wordIdx <= wordIdx + 32'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader; memory writes checked through an expected-write scoreboard.
module tb_imem_boot_loader;
  localparam int AW  = 4;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_reset;
  logic          busy;
  logic          done;
  logic          error;

  int checks = 0;
  int errors = 0;
  logic [AW+31:0] expQ[$];
  logic [31:0]    img[$];

  imem_boot_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_reset(core_reset), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the next expected write.
  initial begin
    logic [AW+31:0] e;
    forever begin
      @(negedge clk);
      if (imem_we) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: addr %h data %h, expected no write", imem_addr, imem_wdata);
        end else begin
          e = expQ.pop_front();
          if ({imem_addr, imem_wdata} !== e) begin
            errors++;
            $display("FAIL write: addr %h data %h, expected addr %h data %h",
                     imem_addr, imem_wdata, e[AW+31:32], e[31:0]);
          end
        end
        chk("core_reset_during_write", core_reset, 1);
      end
    end
  end

  task automatic sendByte(input logic [7:0] b, input int gap);
    bit taken = 0;
    rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    rx_valid = 1'b1;
    rx_data  = b;
    for (int k = 0; k < 50 && !taken; k++) begin
      @(negedge clk);
      if (rx_ready) begin
        @(posedge clk); #1;
        taken = 1;
      end
    end
    rx_valid = 1'b0;
    if (!taken) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: byte %h not accepted, expected acceptance within 50 cycles", b);
    end
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Sends img with its length header, then steps through the final WRITE into DONE.
  task automatic loadImage(input int gapMax);
    int n = img.size();
    sendByte(8'(n >> 8), 0);
    sendByte(8'(n), 0);
    for (int i = 0; i < n; i++) begin
      expQ.push_back({AW'(i), img[i]});
      for (int j = 0; j < 4; j++)
        sendByte(8'(img[i] >> (24 - 8 * j)), (gapMax > 0) ? int'($urandom_range(gapMax, 0)) : 0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    #1;
    chk("rst_core_reset", core_reset, 1);
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_status", {busy, done, error, imem_we}, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Basic two-word load with latency checks
    pulseStart();
    chk("basic_busy", {busy, core_reset}, 2'b11);
    sendByte(8'h00, 0); sendByte(8'h02, 0);
    expQ.push_back({AW'(0), 32'h12345678});
    expQ.push_back({AW'(1), 32'h9ABCDEF0});
    sendByte(8'h12, 0); sendByte(8'h34, 0); sendByte(8'h56, 0); sendByte(8'h78, 0);
    @(negedge clk);
    chk("basic_w0_we", imem_we, 1);
    chk("basic_w0_rdy", rx_ready, 0);
    chk("basic_w0_data", imem_wdata, 32'h12345678);
    sendByte(8'h9A, 0); sendByte(8'hBC, 0); sendByte(8'hDE, 0); sendByte(8'hF0, 0);
    @(negedge clk);
    chk("basic_w1_addr", imem_addr, 1);
    @(posedge clk); #1;
    chk("basic_done", done, 1);
    chk("basic_core_release", core_reset, 0);
    chk("basic_idle_flags", {busy, rx_ready, error}, 0);

    // Zero-length image from DONE
    pulseStart();
    chk("zero_restart", {done, core_reset}, 2'b01);
    sendByte(8'h00, 0); sendByte(8'h00, 0);
    chk("zero_done", {done, core_reset, busy}, 3'b100);

    // Oversize length (17 > 16)
    pulseStart();
    sendByte(8'h00, 0); sendByte(8'h11, 0);
    chk("over_err", {error, core_reset, rx_ready, busy}, 4'b1100);
    rx_valid = 1'b1; rx_data = 8'h55;
    repeat (3) begin @(posedge clk); #1; end
    chk("over_err_hold", {error, rx_ready}, 2'b10);
    rx_valid = 1'b0;
    pulseStart();
    chk("over_restart", {error, busy}, 2'b01);
    img.delete(); img.push_back(32'hCAFEBABE);
    loadImage(0);
    chk("over_recover_done", {done, core_reset}, 2'b10);

    // Gapped stream, bytes held across WRITE
    pulseStart();
    img.delete();
    img.push_back(32'hDEADBEEF); img.push_back(32'h01020304); img.push_back(32'hA5A55A5A);
    loadImage(5);
    chk("gap_done", done, 1);

    // Full-depth image: addresses 0..15
    pulseStart();
    img.delete();
    for (int i = 0; i < 16; i++) img.push_back(32'h11111111 * i + 32'h00C0FFEE);
    loadImage(0);
    chk("full_done", done, 1);
    chk("full_last_addr", imem_addr, 15);

    // Idle timeout inside a word
    pulseStart();
    sendByte(8'h00, 0); sendByte(8'h01, 0); sendByte(8'hAA, 0);
    repeat (TMO - 1) begin @(posedge clk); #1; end
    chk("tmo_not_yet", {busy, error}, 2'b10);
    @(posedge clk); #1;
    chk("tmo_err", {error, busy, core_reset}, 3'b101);

    // Asynchronous reset after 2 of 4 data bytes
    pulseStart();
    sendByte(8'h00, 0); sendByte(8'h02, 0); sendByte(8'h11, 0); sendByte(8'h22, 0);
    #3 reset = 1'b1;
    #1;
    chk("areset_core_reset", core_reset, 1);
    chk("areset_flags", {rx_ready, imem_we, busy, done, error}, 0);
    chk("areset_addr", imem_addr, 0);
    chk("areset_wdata", imem_wdata, 0);
    @(posedge clk); #1 reset = 1'b0;
    pulseStart();
    img.delete(); img.push_back(32'h76543210); img.push_back(32'hFEDCBA98);
    loadImage(2);
    chk("areset_reload_done", {done, core_reset}, 2'b10);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
